// File: rtl/sc_peak_detector.sv
// Schmidl-Cox back end: divider-free (|P|^2 << FRAC) > thresh*R^2 test plus peak-search FSM.
// 3-cycle latency; a single enable stalls every stage while o_tvalid && !o_tready.
module sc_peak_detector #(
  parameter int P_WIDTH      = 16,
  parameter int R_WIDTH      = 16,
  parameter int THRESH_WIDTH = 16,
  parameter int THRESH_FRAC  = 15,
  parameter int LEN_WIDTH    = 10,
  parameter int IDX_WIDTH    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [THRESH_WIDTH-1:0]      thresh,
  input  logic [LEN_WIDTH-1:0]         search_len,
  input  logic [LEN_WIDTH-1:0]         holdoff_len,
  input  logic [2*P_WIDTH+R_WIDTH-1:0] i_tdata,
  input  logic                         i_tlast,
  input  logic                         i_tvalid,
  output logic                         i_tready,
  output logic [2*P_WIDTH+R_WIDTH-1:0] o_tdata,
  output logic                         o_tuser,
  output logic                         o_tlast,
  output logic                         o_tvalid,
  input  logic                         o_tready,
  output logic                         peak_valid,
  output logic [IDX_WIDTH-1:0]         peak_idx,
  output logic [2*P_WIDTH:0]           peak_mag
);
  localparam int D_W   = 2*P_WIDTH + R_WIDTH;
  localparam int SQ_W  = 2*P_WIDTH;
  localparam int MAG_W = 2*P_WIDTH + 1;
  localparam int R2_W  = 2*R_WIDTH;
  localparam int TR_W  = THRESH_WIDTH + R2_W;
  localparam int CMP_W = (MAG_W + THRESH_FRAC > TR_W) ? MAG_W + THRESH_FRAC : TR_W;

  logic flush, en, xfer;
  assign flush    = reset || clear;
  assign en       = !o_tvalid || o_tready;
  assign i_tready = en && !flush;
  assign xfer     = o_tvalid && o_tready;

  logic signed [P_WIDTH-1:0] in_pi, in_pq;
  logic [R_WIDTH-1:0]        in_r;
  logic signed [SQ_W-1:0]    pi_sq, pq_sq;
  logic [R2_W-1:0]           r_sq;
  assign in_pi = i_tdata[D_W-1 -: P_WIDTH];
  assign in_pq = i_tdata[R_WIDTH +: P_WIDTH];
  assign in_r  = i_tdata[R_WIDTH-1:0];
  assign pi_sq = SQ_W'(in_pi) * SQ_W'(in_pi);
  assign pq_sq = SQ_W'(in_pq) * SQ_W'(in_pq);
  assign r_sq  = R2_W'(in_r) * R2_W'(in_r);

  logic             s1_vld, s1_last, s1_rnz, s2_vld, s2_last, s2_rnz;
  logic [D_W-1:0]   s1_dat, s2_dat;
  logic [SQ_W-1:0]  s1_pi2, s1_pq2;
  logic [R2_W-1:0]  s1_r2;
  logic [MAG_W-1:0] s2_mag, s3_mag;
  logic [TR_W-1:0]  s2_tr;
  logic [CMP_W-1:0] lhs, rhs;
  // Both sides widened so neither the shift nor the product loses bits.
  assign lhs = CMP_W'(s2_mag) << THRESH_FRAC;
  assign rhs = CMP_W'(s2_tr);

  always_ff @(posedge clk) begin
    if (flush) begin
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
      o_tvalid <= 1'b0;
      o_tuser  <= 1'b0;
      o_tlast  <= 1'b0;
    end else if (en) begin
      s1_vld   <= i_tvalid;
      s1_dat   <= i_tdata;
      s1_last  <= i_tlast;
      s1_pi2   <= $unsigned(pi_sq);
      s1_pq2   <= $unsigned(pq_sq);
      s1_r2    <= r_sq;
      s1_rnz   <= (in_r != '0);
      s2_vld   <= s1_vld;
      s2_dat   <= s1_dat;
      s2_last  <= s1_last;
      s2_mag   <= MAG_W'(s1_pi2) + MAG_W'(s1_pq2);
      s2_tr    <= TR_W'(thresh) * TR_W'(s1_r2);
      s2_rnz   <= s1_rnz;
      o_tvalid <= s2_vld;
      o_tdata  <= s2_dat;
      o_tlast  <= s2_vld && s2_last;
      o_tuser  <= s2_vld && s2_rnz && (lhs > rhs);
      s3_mag   <= s2_mag;
    end
  end

  typedef enum logic [1:0] {IDLE, SEARCH, HOLDOFF} state_t;
  state_t               state, state_n;
  logic [IDX_WIDTH-1:0] cnt, cnt_n, best_idx, best_idx_n, peak_idx_n;
  logic [MAG_W-1:0]     best_mag, best_mag_n, peak_mag_n;
  logic [LEN_WIDTH-1:0] remain, remain_n, hold_len, hold_len_n, hold_cnt, hold_cnt_n, sl_eff;
  logic                 report;

  assign sl_eff = (search_len == '0) ? LEN_WIDTH'(1) : search_len;

  // remain counts search beats still to come after the current one.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    best_idx_n = best_idx;
    best_mag_n = best_mag;
    remain_n   = remain;
    hold_len_n = hold_len;
    hold_cnt_n = hold_cnt;
    peak_idx_n = peak_idx;
    peak_mag_n = peak_mag;
    report     = 1'b0;
    if (xfer) begin
      cnt_n = cnt + IDX_WIDTH'(1);
      case (state)
        IDLE: if (o_tuser) begin
          state_n    = SEARCH;
          best_mag_n = s3_mag;
          best_idx_n = cnt;
          remain_n   = sl_eff - LEN_WIDTH'(1);
          hold_len_n = holdoff_len;
          report     = (sl_eff == LEN_WIDTH'(1)) || o_tlast;
        end
        SEARCH: begin
          if (s3_mag > best_mag) begin
            best_mag_n = s3_mag;
            best_idx_n = cnt;
          end
          if (remain <= LEN_WIDTH'(1) || o_tlast) report = 1'b1;
          else remain_n = remain - LEN_WIDTH'(1);
        end
        HOLDOFF: begin
          hold_cnt_n = hold_cnt - LEN_WIDTH'(1);
          if (hold_cnt == LEN_WIDTH'(1)) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
    if (report) begin
      peak_idx_n = best_idx_n;
      peak_mag_n = best_mag_n;
      hold_cnt_n = hold_len_n;
      state_n    = (hold_len_n == '0) ? IDLE : HOLDOFF;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state      <= IDLE;
      cnt        <= '0;
      best_idx   <= '0;
      best_mag   <= '0;
      remain     <= '0;
      hold_len   <= '0;
      hold_cnt   <= '0;
      peak_valid <= 1'b0;
      peak_idx   <= '0;
      peak_mag   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      best_idx   <= best_idx_n;
      best_mag   <= best_mag_n;
      remain     <= remain_n;
      hold_len   <= hold_len_n;
      hold_cnt   <= hold_cnt_n;
      peak_valid <= report;
      peak_idx   <= peak_idx_n;
      peak_mag   <= peak_mag_n;
    end
  end
endmodule

// File: tb/tb_sc_peak_detector.sv
// Bench for sc_peak_detector: randomized and directed beats checked against a scan-based
// reference of the threshold rule and the search/holdoff windows.
`timescale 1ns/1ps
module tb_sc_peak_detector;
  localparam int TF = 15;
  localparam int LW = 10;

  logic        clk = 1'b0;
  logic        reset, clear, i_tlast, i_tvalid, i_tready, o_tuser, o_tlast, o_tvalid, o_tready;
  logic        peak_valid;
  logic [15:0] thresh;
  logic [LW-1:0] search_len, holdoff_len;
  logic [47:0] i_tdata, o_tdata;
  logic [31:0] peak_idx;
  logic [32:0] peak_mag;

  always #5 clk = ~clk;

  sc_peak_detector dut (
    .clk(clk), .reset(reset), .clear(clear), .thresh(thresh),
    .search_len(search_len), .holdoff_len(holdoff_len),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
    .o_tready(o_tready), .peak_valid(peak_valid), .peak_idx(peak_idx), .peak_mag(peak_mag)
  );

  typedef struct { logic signed [15:0] pi; logic signed [15:0] pq; logic [15:0] r; logic last; } beat_t;
  typedef struct { logic [47:0] dat; logic last; logic tu; longint mag; } exp_t;
  typedef struct { longint idx; longint mag; int at; } pk_t;

  beat_t  stim_q[$];
  exp_t   exp_q[$];
  pk_t    pk_q[$], mpk_q[$];
  longint ph_mag[$];
  bit     ph_tu[$], ph_last[$], obs_tu[$];
  int     xfers = 0;
  int     total = 0, bad = 0;
  int     cfg_sl, cfg_ho;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input int pi, input int pq, input int r, input bit last);
    beat_t b;
    b.pi = 16'(pi); b.pq = 16'(pq); b.r = 16'(r); b.last = last;
    return b;
  endfunction

  // Reference: |P|^2 and the threshold rule in plain 64-bit arithmetic.
  function automatic exp_t model_beat(input beat_t b, input logic [15:0] th);
    longint pi, pq, r, m;
    exp_t e;
    pi = b.pi; pq = b.pq; r = longint'(b.r);
    m = pi*pi + pq*pq;
    e.dat  = {b.pi, b.pq, b.r};
    e.last = b.last;
    e.mag  = m;
    e.tu   = (r != 0) && ((m << TF) > longint'(th) * r * r);
    return e;
  endfunction

  // Reference peaks: scan transferred beats, open a window on each crossing outside holdoff.
  task automatic model_peaks(input int sl, input int ho);
    int n, i, len;
    n = ph_mag.size(); i = 0; len = (sl == 0) ? 1 : sl;
    mpk_q.delete();
    while (i < n) begin
      if (!ph_tu[i]) i++;
      else begin
        int e, best;
        e = -1;
        for (int k = i; k < n; k++) if (k - i + 1 == len || ph_last[k]) begin e = k; break; end
        if (e < 0) break;
        best = i;
        for (int k = i + 1; k <= e; k++) if (ph_mag[k] > ph_mag[best]) best = k;
        mpk_q.push_back('{idx: longint'(best), mag: ph_mag[best], at: e + 1});
        i = e + 1 + ho;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset || clear) exp_q.delete();
    else begin
      if (peak_valid) pk_q.push_back('{idx: longint'(peak_idx), mag: longint'(peak_mag), at: xfers});
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) chk("extra_beat", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("o_tdata", 64'(o_tdata), 64'(e.dat));
          chk("o_tlast", 64'(o_tlast), 64'(e.last));
          chk("o_tuser", 64'(o_tuser), 64'(e.tu));
          ph_mag.push_back(e.mag); ph_tu.push_back(e.tu); ph_last.push_back(e.last);
          obs_tu.push_back(o_tuser);
          xfers++;
        end
      end
      if (i_tvalid && i_tready && stim_q.size() > 0) exp_q.push_back(model_beat(stim_q[0], thresh));
    end
  end

  task automatic clr_vars();
    pk_q.delete(); ph_mag.delete(); ph_tu.delete(); ph_last.delete(); obs_tu.delete();
    xfers = 0;
  endtask

  task automatic start_phase(input int sl, input int ho, input logic [15:0] th);
    @(posedge clk); #1;
    i_tvalid = 1'b0; o_tready = 1'b0; clear = 1'b1;
    search_len = LW'(sl); holdoff_len = LW'(ho); thresh = th;
    cfg_sl = sl; cfg_ho = ho;
    @(posedge clk); #1;
    clear = 1'b0;
    clr_vars();
  endtask

  // mode 0: always ready, no gaps; 1: random gaps and backpressure; 2: 10-cycle stall first.
  task automatic run_stim(input int mode);
    bit acc;
    int cyc;
    acc = 1'b0; cyc = 0;
    while (stim_q.size() > 0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (acc) begin void'(stim_q.pop_front()); i_tvalid = 1'b0; end
      if (mode == 0) o_tready = 1'b1;
      else if (mode == 1) o_tready = ($urandom_range(0, 3) != 0);
      else o_tready = (cyc > 10);
      if (!i_tvalid && stim_q.size() > 0 && (mode != 1 || $urandom_range(0, 3) != 0)) begin
        i_tvalid = 1'b1;
        i_tdata  = {stim_q[0].pi, stim_q[0].pq, stim_q[0].r};
        i_tlast  = stim_q[0].last;
      end
      @(negedge clk);
      acc = i_tvalid && i_tready;
    end
    chk("stim_left", 64'(stim_q.size()), 64'd0);
    stim_q.delete();
  endtask

  task automatic end_phase(input string nm);
    int cyc;
    cyc = 0;
    @(posedge clk); #1;
    i_tvalid = 1'b0; o_tready = 1'b1;
    while (exp_q.size() > 0 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_drain"}, 64'(exp_q.size()), 64'd0);
    model_peaks(cfg_sl, cfg_ho);
    chk({nm, "_npk"}, 64'(pk_q.size()), 64'(mpk_q.size()));
    for (int k = 0; k < mpk_q.size() && k < pk_q.size(); k++) begin
      chk({nm, "_pk_idx"}, 64'(pk_q[k].idx), 64'(mpk_q[k].idx));
      chk({nm, "_pk_mag"}, 64'(pk_q[k].mag), 64'(mpk_q[k].mag));
      chk({nm, "_pk_at"},  64'(pk_q[k].at),  64'(mpk_q[k].at));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    reset = 1'b1; clear = 1'b0; i_tvalid = 1'b0; i_tdata = '0; i_tlast = 1'b0; o_tready = 1'b1;
    thresh = 16'h4000; search_len = LW'(4); holdoff_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i_tready", 64'(i_tready), 64'd0);
    chk("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    chk("rst_o_tuser", 64'(o_tuser), 64'd0);
    chk("rst_o_tlast", 64'(o_tlast), 64'd0);
    chk("rst_peak_valid", 64'(peak_valid), 64'd0);
    chk("rst_peak_idx", 64'(peak_idx), 64'd0);
    chk("rst_peak_mag", 64'(peak_mag), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Latency, then threshold examples.
    start_phase(4, 0, 16'h4000);
    o_tready = 1'b1;
    stim_q.push_back(mk(100, 0, 100, 1'b0));
    i_tvalid = 1'b1; i_tdata = {16'sd100, 16'sd0, 16'd100}; i_tlast = 1'b0;
    @(negedge clk);
    chk("lat_accept", 64'(i_tready), 64'd1);
    @(posedge clk); #1;
    i_tvalid = 1'b0; void'(stim_q.pop_front());
    lat = 1;
    while (!o_tvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", 64'(lat), 64'd3);
    stim_q.push_back(mk(100, 0, 0, 1'b0));
    stim_q.push_back(mk(70, 0, 100, 1'b0));
    run_stim(0);
    end_phase("thr");
    chk("thr_n", 64'(obs_tu.size()), 64'd3);
    if (obs_tu.size() == 3) begin
      chk("thr_100_100", 64'(obs_tu[0]), 64'd1);
      chk("thr_r_zero", 64'(obs_tu[1]), 64'd0);
      chk("thr_70_100", 64'(obs_tu[2]), 64'd0);
    end

    // Stall: 5 beats offered while o_tready is held low for 10 cycles.
    start_phase(4, 0, 16'h4000);
    for (int k = 0; k < 5; k++) stim_q.push_back(mk(10 * k + 3, -7 * k, 20 + k, k == 4));
    run_stim(2);
    end_phase("stall");
    chk("stall_count", 64'(xfers), 64'd5);

    // Peak ramp at indices 10..13.
    start_phase(4, 0, 16'h4000);
    for (int k = 0; k < 10; k++) stim_q.push_back(mk(5, 0, 10, 1'b0));
    stim_q.push_back(mk(50, 50, 10, 1'b0));
    stim_q.push_back(mk(90, 30, 10, 1'b0));
    stim_q.push_back(mk(30, 90, 10, 1'b0));
    stim_q.push_back(mk(84, 0, 10, 1'b0));
    for (int k = 0; k < 4; k++) stim_q.push_back(mk(5, 0, 10, 1'b0));
    run_stim(0);
    end_phase("peak");
    chk("peak_n", 64'(pk_q.size()), 64'd1);
    if (pk_q.size() > 0) begin
      chk("peak_idx", 64'(pk_q[0].idx), 64'd11);
      chk("peak_mag", 64'(pk_q[0].mag), 64'd9000);
    end

    // Holdoff spacing with continuously above-threshold beats.
    start_phase(4, 8, 16'h4000);
    for (int k = 0; k < 40; k++)
      stim_q.push_back(mk(20 + $urandom_range(0, 100), $urandom_range(0, 50), 10, 1'b0));
    run_stim(1);
    end_phase("hold");
    chk("hold_n", 64'(pk_q.size()), 64'd4);
    for (int k = 1; k < pk_q.size(); k++)
      chk("hold_gap", 64'(pk_q[k].at - pk_q[k-1].at), 64'd12);

    // tlast ends a search early.
    start_phase(16, 0, 16'h4000);
    stim_q.push_back(mk(60, 0, 10, 1'b0));
    stim_q.push_back(mk(80, 0, 10, 1'b1));
    for (int k = 0; k < 3; k++) stim_q.push_back(mk(5, 0, 10, 1'b0));
    stim_q.push_back(mk(70, 0, 10, 1'b1));
    stim_q.push_back(mk(5, 0, 10, 1'b0));
    run_stim(0);
    end_phase("tlast");
    chk("tlast_n", 64'(pk_q.size()), 64'd2);
    if (pk_q.size() > 0) begin
      chk("tlast_at", 64'(pk_q[0].at), 64'd2);
      chk("tlast_idx", 64'(pk_q[0].idx), 64'd1);
    end

    // clear in the middle of a search.
    start_phase(16, 0, 16'h4000);
    for (int k = 0; k < 8; k++) stim_q.push_back(mk(100, 0, 10, 1'b0));
    run_stim(0);
    @(posedge clk); #1;
    o_tready = 1'b0; clear = 1'b1;
    @(negedge clk);
    chk("clr_i_tready", 64'(i_tready), 64'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_o_tvalid", 64'(o_tvalid), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("clr_no_peak", 64'(pk_q.size()), 64'd0);
    clr_vars();
    search_len = LW'(2); cfg_sl = 2;
    stim_q.push_back(mk(100, 0, 10, 1'b0));
    stim_q.push_back(mk(5, 0, 10, 1'b0));
    stim_q.push_back(mk(5, 0, 10, 1'b0));
    run_stim(0);
    end_phase("clr2");
    if (pk_q.size() > 0) chk("clr_idx0", 64'(pk_q[0].idx), 64'd0);

    // Randomized phases.
    for (int ph = 0; ph < 4; ph++) begin
      start_phase($urandom_range(2, 6), $urandom_range(0, 5), 16'($urandom_range(16'h2000, 16'h8000)));
      for (int k = 0; k < 50; k++) begin
        int pi, pq, r;
        pi = int'($urandom_range(0, 300)) - 150;
        pq = int'($urandom_range(0, 300)) - 150;
        r  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 120));
        if ($urandom_range(0, 19) == 0) pi = -32768;
        stim_q.push_back(mk(pi, pq, r, $urandom_range(0, 9) == 0));
      end
      run_stim(1);
      end_phase("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
